// File: rtl/instr_fetch_unit_pkg.sv
// phi_fetch_pkg: shared fetch FSM states and instruction layout constants.
package phi_fetch_pkg;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;

    function automatic logic [5:0] opcodeOf(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches words over req/ack and hands them to decode over valid/ready.
module instr_fetch_unit
    import phi_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    input  logic        ifid_ready,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misalign_err
);

    fetch_state_t state, stateNext;
    logic [31:0]  pc, pcNext, reqAddr, reqAddrNext;
    logic [31:0]  slotInstr, slotInstrNext, slotPc, slotPcNext;
    logic         slotValid, slotValidNext, errFlag, errFlagNext;
    logic [31:0]  targetAligned;

    assign targetAligned = {redirect_target[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            reqAddr   <= RESET_PC;
            slotInstr <= '0;
            slotPc    <= '0;
            slotValid <= 1'b0;
            errFlag   <= 1'b0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            reqAddr   <= reqAddrNext;
            slotInstr <= slotInstrNext;
            slotPc    <= slotPcNext;
            slotValid <= slotValidNext;
            errFlag   <= errFlagNext;
        end
    end

    // A redirect always retargets the PC; the case below only decides what happens to in-flight work.
    always_comb begin
        stateNext     = state;
        pcNext        = redirect_valid ? targetAligned : pc;
        reqAddrNext   = reqAddr;
        slotInstrNext = slotInstr;
        slotPcNext    = slotPc;
        slotValidNext = slotValid;
        errFlagNext   = errFlag | (redirect_valid && (redirect_target[1:0] != 2'b00));
        case (state)
            IDLE: begin
                if (!redirect_valid && fetch_enable) begin
                    stateNext   = REQ;
                    reqAddrNext = pc;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    stateNext = imem_ack ? IDLE : DISCARD;
                end else if (imem_ack) begin
                    stateNext     = HOLD;
                    slotInstrNext = imem_rdata;
                    slotPcNext    = pc;
                    slotValidNext = 1'b1;
                    pcNext        = pc + INSTR_BYTES;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    stateNext     = IDLE;
                    slotValidNext = 1'b0;
                end else if (slotValid && ifid_ready) begin
                    slotValidNext = 1'b0;
                    stateNext     = fetch_enable ? REQ : IDLE;
                    reqAddrNext   = fetch_enable ? pc : reqAddr;
                end
            end
            DISCARD: begin
                // The stale word is dropped; a redirect arriving with the ack leaves nothing in flight.
                if (imem_ack) begin
                    stateNext   = (fetch_enable && !redirect_valid) ? REQ : IDLE;
                    reqAddrNext = (fetch_enable && !redirect_valid) ? pc : reqAddr;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign imem_req      = (state == REQ) || (state == DISCARD);
    assign imem_addr     = reqAddr;
    assign ifid_valid    = slotValid;
    assign ifid_instr    = slotInstr;
    assign ifid_pc       = slotPc;
    assign ifid_pc_plus4 = slotPc + INSTR_BYTES;
    assign misalign_err  = errFlag;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table, async-reset and RESET_PC sequences, then randomized traffic against a stream model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_enable = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ifid_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;

    logic        imem_req, ifid_valid, misalign_err;
    logic [31:0] imem_addr, ifid_instr, ifid_pc, ifid_pc_plus4;
    logic        hiReq, hiValid, hiErr;
    logic [31:0] hiAddr, hiInstr, hiPc, hiPcPlus4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_enable(fetch_enable),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_ready(ifid_ready), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target), .misalign_err(misalign_err)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutHi (
        .clk(clk), .rst_n(rst_n), .fetch_enable(fetch_enable),
        .imem_req(hiReq), .imem_addr(hiAddr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ifid_valid(hiValid), .ifid_ready(ifid_ready), .ifid_instr(hiInstr),
        .ifid_pc(hiPc), .ifid_pc_plus4(hiPcPlus4),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target), .misalign_err(hiErr)
    );

    typedef struct {
        logic        fe, ack, rdy, rv;
        logic [31:0] rdata, tgt;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstr, ePc;
        logic        eErr;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic setIdleInputs();
        fetch_enable = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        ifid_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        setIdleInputs();
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(ifid_valid), 0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_pc4", ifid_pc_plus4, 32'h4);
        chk("rst_err", 32'(misalign_err), 0);
        chk("rst_hi_addr", hiAddr, 32'hFFFF_FFFC);
        rst_n = 1'b1;
    endtask

    initial begin
        // fe ack rdy rv rdata tgt | req addr valid instr pc err
        tbl[0]  = '{1, 0, 0, 0, 32'h0,         32'h0,  1, 32'h0,  0, 32'h0,         32'h0,  0};
        tbl[1]  = '{1, 1, 0, 0, 32'h8C01_0004, 32'h0,  0, 32'h0,  1, 32'h8C01_0004, 32'h0,  0};
        tbl[2]  = '{1, 0, 1, 0, 32'h0,         32'h0,  1, 32'h4,  0, 32'h0,         32'h0,  0};
        tbl[3]  = '{1, 1, 0, 0, 32'h0022_1820, 32'h0,  0, 32'h4,  1, 32'h0022_1820, 32'h4,  0};
        tbl[4]  = '{1, 0, 0, 0, 32'h0,         32'h0,  0, 32'h4,  1, 32'h0022_1820, 32'h4,  0};
        tbl[5]  = '{1, 0, 0, 0, 32'h0,         32'h0,  0, 32'h4,  1, 32'h0022_1820, 32'h4,  0};
        tbl[6]  = '{1, 0, 0, 0, 32'h0,         32'h0,  0, 32'h4,  1, 32'h0022_1820, 32'h4,  0};
        tbl[7]  = '{1, 0, 0, 0, 32'h0,         32'h0,  0, 32'h4,  1, 32'h0022_1820, 32'h4,  0};
        tbl[8]  = '{1, 0, 0, 0, 32'h0,         32'h0,  0, 32'h4,  1, 32'h0022_1820, 32'h4,  0};
        tbl[9]  = '{1, 0, 1, 0, 32'h0,         32'h0,  1, 32'h8,  0, 32'h0,         32'h0,  0};
        tbl[10] = '{1, 0, 0, 1, 32'h0,         32'h40, 1, 32'h8,  0, 32'h0,         32'h0,  0};
        tbl[11] = '{1, 0, 0, 0, 32'h0,         32'h0,  1, 32'h8,  0, 32'h0,         32'h0,  0};
        tbl[12] = '{1, 0, 0, 0, 32'h0,         32'h0,  1, 32'h8,  0, 32'h0,         32'h0,  0};
        tbl[13] = '{1, 1, 0, 0, 32'hDEAD_BEEF, 32'h0,  1, 32'h40, 0, 32'h0,         32'h0,  0};
        tbl[14] = '{1, 1, 0, 0, 32'h1111_1111, 32'h0,  0, 32'h40, 1, 32'h1111_1111, 32'h40, 0};
        tbl[15] = '{1, 0, 1, 1, 32'h0,         32'h43, 0, 32'h40, 0, 32'h0,         32'h0,  1};
        tbl[16] = '{1, 0, 0, 0, 32'h0,         32'h0,  1, 32'h40, 0, 32'h0,         32'h0,  1};
        tbl[17] = '{0, 1, 0, 0, 32'h2222_2222, 32'h0,  0, 32'h40, 1, 32'h2222_2222, 32'h40, 1};
        tbl[18] = '{0, 0, 1, 0, 32'h0,         32'h0,  0, 32'h40, 0, 32'h0,         32'h0,  1};
        tbl[19] = '{0, 0, 0, 0, 32'h0,         32'h0,  0, 32'h40, 0, 32'h0,         32'h0,  1};

        doReset();
        for (int i = 0; i < 20; i++) begin
            fetch_enable = tbl[i].fe; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
            ifid_ready = tbl[i].rdy; redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
            @(posedge clk); #1;
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(tbl[i].eReq));
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].eAddr);
            chk($sformatf("v%0d_valid", i), 32'(ifid_valid), 32'(tbl[i].eValid));
            chk($sformatf("v%0d_err", i), 32'(misalign_err), 32'(tbl[i].eErr));
            if (tbl[i].eValid) begin
                chk($sformatf("v%0d_instr", i), ifid_instr, tbl[i].eInstr);
                chk($sformatf("v%0d_pc", i), ifid_pc, tbl[i].ePc);
                chk($sformatf("v%0d_pc4", i), ifid_pc_plus4, tbl[i].ePc + 32'd4);
            end
            @(negedge clk);
        end

        // Asynchronous reset while a request is outstanding.
        doReset();
        fetch_enable = 1'b1;
        @(posedge clk); #1;
        chk("ar_req_before", 32'(imem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req_async", 32'(imem_req), 0);
        chk("ar_valid_async", 32'(ifid_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ar_restart_req", 32'(imem_req), 1);
        chk("ar_restart_addr", imem_addr, 32'h0);

        // RESET_PC at the top of the address space wraps.
        doReset();
        fetch_enable = 1'b1;
        @(posedge clk); #1;
        chk("hi_addr0", hiAddr, 32'hFFFF_FFFC);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hABCD_0123;
        @(posedge clk); #1;
        chk("hi_valid", 32'(hiValid), 1);
        chk("hi_pc", hiPc, 32'hFFFF_FFFC);
        chk("hi_pc4", hiPcPlus4, 32'h0);
        chk("hi_instr", hiInstr, 32'hABCD_0123);
        @(negedge clk);
        imem_ack = 1'b0; ifid_ready = 1'b1;
        @(posedge clk); #1;
        chk("hi_next_req", 32'(hiReq), 1);
        chk("hi_next_addr", hiAddr, 32'h0);

        // Randomized traffic: the model tracks which PC the next delivered instruction must carry.
        doReset();
        begin
            logic [31:0] expPc, prevAddr, prevInstr, prevPc;
            logic        expErr, prevPending, prevHold;
            int          waitCnt, delivered;
            expPc = 32'h0; expErr = 1'b0; prevPending = 1'b0; prevHold = 1'b0;
            prevAddr = '0; prevInstr = '0; prevPc = '0;
            waitCnt = $urandom_range(0, 3); delivered = 0;
            for (int c = 0; c < 3000; c++) begin
                fetch_enable = ($urandom_range(0, 99) < 85);
                ifid_ready = ($urandom_range(0, 99) < 70);
                redirect_valid = ($urandom_range(0, 99) < 5);
                redirect_target = {16'h0, 14'($urandom_range(0, 16383)), 2'b00}
                                  | 32'($urandom_range(0, 9) == 0);
                imem_ack = 1'b0; imem_rdata = '0;
                if (imem_req) begin
                    if (waitCnt == 0) begin
                        imem_ack = 1'b1;
                        imem_rdata = memWord(imem_addr);
                        waitCnt = $urandom_range(0, 3);
                    end else waitCnt--;
                end
                #1;
                chk("rnd_err", 32'(misalign_err), 32'(expErr));
                if (prevPending) begin
                    chk("rnd_req_held", 32'(imem_req), 1);
                    chk("rnd_addr_held", imem_addr, prevAddr);
                end
                if (prevHold) begin
                    chk("rnd_slot_held", 32'(ifid_valid), 1);
                    chk("rnd_instr_held", ifid_instr, prevInstr);
                    chk("rnd_pc_held", ifid_pc, prevPc);
                end
                if (ifid_valid && ifid_ready && !redirect_valid) begin
                    chk("rnd_pc", ifid_pc, expPc);
                    chk("rnd_instr", ifid_instr, memWord(expPc));
                    chk("rnd_pc4", ifid_pc_plus4, expPc + 32'd4);
                    expPc = expPc + 32'd4;
                    delivered++;
                end
                if (redirect_valid) begin
                    expPc = redirect_target & 32'hFFFF_FFFC;
                    expErr = expErr | (redirect_target[1:0] != 2'b00);
                end
                prevPending = imem_req && !imem_ack;
                prevAddr = imem_addr;
                prevHold = ifid_valid && !ifid_ready && !redirect_valid;
                prevInstr = ifid_instr;
                prevPc = ifid_pc;
                @(negedge clk);
            end
            chk("rnd_throughput", 32'(delivered >= 40), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
